// File: rtl/clint_pkg.sv
// CLINT register offsets, access-size encodings, register selector and write-merge helper.
`include "config.svh"

package clint_pkg;

    localparam logic [`ADDR_WIDTH-1:0] OFF_MSIP        = `ADDR_WIDTH'(32'h0000_0000);
    localparam logic [`ADDR_WIDTH-1:0] OFF_MTIMECMP_LO = `ADDR_WIDTH'(32'h0000_4000);
    localparam logic [`ADDR_WIDTH-1:0] OFF_MTIMECMP_HI = `ADDR_WIDTH'(32'h0000_4004);
    localparam logic [`ADDR_WIDTH-1:0] OFF_MTIME_LO    = `ADDR_WIDTH'(32'h0000_BFF8);
    localparam logic [`ADDR_WIDTH-1:0] OFF_MTIME_HI    = `ADDR_WIDTH'(32'h0000_BFFC);

    localparam int unsigned MTIME_DIV_DEFAULT = 10;

    typedef enum logic [`SIZE_WIDTH-1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_TIME_LO,
        REG_TIME_HI
    } reg_e;

    // Decode on the aligned word address; byte-lane bits are handled by merge().
    function automatic reg_e decode(input logic [`ADDR_WIDTH-1:0] addr);
        logic [`ADDR_WIDTH-1:0] word;
        word = {addr[`ADDR_WIDTH-1:2], 2'b00};
        case (word)
            OFF_MSIP:        return REG_MSIP;
            OFF_MTIMECMP_LO: return REG_CMP_LO;
            OFF_MTIMECMP_HI: return REG_CMP_HI;
            OFF_MTIME_LO:    return REG_TIME_LO;
            OFF_MTIME_HI:    return REG_TIME_HI;
            default:         return REG_NONE;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [`REG_DATA_WIDTH-1:0] data,
                                          input logic [1:0] lane,
                                          input size_e size);
        logic [31:0] res;
        res = old;
        case (size)
            SIZE_BYTE: res[{lane, 3'b000} +: 8]       = data[7:0];
            SIZE_HALF: res[{lane[1], 4'b0000} +: 16]  = data[15:0];
            SIZE_WORD: res                            = data[31:0];
            default:   res                            = old;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/clint_timer.sv
// 64-bit mtime counter with bus-write override; optional prescaler under CLINT_MTIME_PRESCALER_EN.
module clint_timer
    import clint_pkg::*;
#(
    parameter int unsigned MTIME_DIV = MTIME_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wr_data,
    output logic [63:0] mtime
);

    logic tick;

`ifdef CLINT_MTIME_PRESCALER_EN
    localparam int unsigned CW = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(MTIME_DIV - 1);

    logic [CW-1:0] pres;

    // Prescaler keeps running even when a bus write overrides mtime.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pres <= '0;
        end else if (pres == LAST) begin
            pres <= '0;
        end else begin
            pres <= pres + CW'(1);
        end
    end

    assign tick = (pres == LAST);
`else
    localparam int unsigned unused_div = MTIME_DIV;
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime <= '0;
        end else if (wr_lo) begin
            mtime[31:0] <= wr_data;
        end else if (wr_hi) begin
            mtime[63:32] <= wr_data;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

endmodule

// File: rtl/config.svh
// Bus and address-map configuration shared by the CLINT sources and the surrounding bus fabric.
`ifndef CLINT_CONFIG_SVH
`define CLINT_CONFIG_SVH
`define ADDR_WIDTH     16
`define SIZE_WIDTH     2
`define REG_DATA_WIDTH 32
`define BUS_DATA_WIDTH 32
`define CLINT_ADDR     32'h0200_0000
`endif

// File: rtl/clint.sv
// Core-local interruptor: msip, mtimecmp, mtime and timer compare. Build macro: CLINT_MTIME_PRESCALER_EN.
`include "config.svh"

module clint
    import clint_pkg::*;
#(
    parameter int unsigned MTIME_DIV = MTIME_DIV_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [`ADDR_WIDTH-1:0]      bus_clint_read_addr,
    input  logic [`ADDR_WIDTH-1:0]      bus_clint_write_addr,
    input  logic [`SIZE_WIDTH-1:0]      bus_clint_read_size,
    input  logic [`SIZE_WIDTH-1:0]      bus_clint_write_size,
    input  logic [`REG_DATA_WIDTH-1:0]  bus_clint_data,
    input  logic                        bus_clint_rd,
    input  logic                        bus_clint_wr,
    output logic [`BUS_DATA_WIDTH-1:0]  clint_bus_data,
    output logic                        clint_int_timer_req,
    output logic                        clint_int_software_req
);

    logic        msip;
    logic [63:0] mtimecmp;
    logic [63:0] mtime;
    reg_e        rsel;
    reg_e        wsel;
    size_e       wsize;
    logic [31:0] rword;
    logic [31:0] wold;
    logic [31:0] wnew;
    logic        wvalid;

    function automatic logic [31:0] reg_word(input reg_e sel);
        case (sel)
            REG_MSIP:    return {31'b0, msip};
            REG_CMP_LO:  return mtimecmp[31:0];
            REG_CMP_HI:  return mtimecmp[63:32];
            REG_TIME_LO: return mtime[31:0];
            REG_TIME_HI: return mtime[63:32];
            default:     return '0;
        endcase
    endfunction

    always_comb begin
        rsel           = decode(bus_clint_read_addr);
        rword          = reg_word(rsel);
        clint_bus_data = '0;
        if (bus_clint_rd && size_e'(bus_clint_read_size) != SIZE_RSVD) begin
            clint_bus_data = `BUS_DATA_WIDTH'(rword);
        end
    end

    always_comb begin
        wsel   = decode(bus_clint_write_addr);
        wsize  = size_e'(bus_clint_write_size);
        wold   = reg_word(wsel);
        wnew   = merge(wold, bus_clint_data, bus_clint_write_addr[1:0], wsize);
        wvalid = bus_clint_wr && (wsel != REG_NONE) && (wsize != SIZE_RSVD)
                 && !(wsize == SIZE_HALF && bus_clint_write_addr[0]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msip     <= 1'b0;
            mtimecmp <= '1;
        end else if (wvalid) begin
            case (wsel)
                REG_MSIP:   msip            <= wnew[0];
                REG_CMP_LO: mtimecmp[31:0]  <= wnew;
                REG_CMP_HI: mtimecmp[63:32] <= wnew;
                default:    ;
            endcase
        end
    end

    // Compare is registered, so MTIP trails an operand change by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clint_int_timer_req <= 1'b0;
        end else begin
            clint_int_timer_req <= (mtime >= mtimecmp);
        end
    end

    assign clint_int_software_req = msip;

    clint_timer #(
        .MTIME_DIV (MTIME_DIV)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .wr_lo   (wvalid && wsel == REG_TIME_LO),
        .wr_hi   (wvalid && wsel == REG_TIME_HI),
        .wr_data (wnew),
        .mtime   (mtime)
    );

endmodule

// File: tb/tb_clint.sv
// Directed plus random checks of clint against an arithmetic reference model of the register map.
module tb_clint;

`ifdef CLINT_MTIME_PRESCALER_EN
    localparam int unsigned DIV = 10;
`else
    localparam int unsigned DIV = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] raddr, waddr;
    logic [1:0]  rsize, wsize;
    logic [31:0] wdata, rdata;
    logic        rd, wr, treq, sreq;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    bit              m_msip;
    longint unsigned m_cmp, m_time;
    bit              m_treq;
    int unsigned     m_cyc;
    logic [31:0]     got;

    int unsigned offs[5] = '{32'h0000, 32'h4000, 32'h4004, 32'hBFF8, 32'hBFFC};

    clint #(.MTIME_DIV(10)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .bus_clint_read_addr    (raddr),
        .bus_clint_write_addr   (waddr),
        .bus_clint_read_size    (rsize),
        .bus_clint_write_size   (wsize),
        .bus_clint_data         (wdata),
        .bus_clint_rd           (rd),
        .bus_clint_wr           (wr),
        .clint_bus_data         (rdata),
        .clint_int_timer_req    (treq),
        .clint_int_software_req (sreq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_reg(input logic [15:0] a);
        for (int i = 0; i < 5; i++)
            if ({a[15:2], 2'b00} == offs[i]) return i + 1;
        return 0;
    endfunction

    function automatic longint unsigned model_word(input int r);
        case (r)
            1: return longint'(m_msip);
            2: return m_cmp & 64'hFFFF_FFFF;
            3: return m_cmp >> 32;
            4: return m_time & 64'hFFFF_FFFF;
            5: return m_time >> 32;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input bit r, input logic [15:0] a, input logic [1:0] s);
        if (!r || s == 2'b11) return 32'h0;
        return 32'(model_word(model_reg(a)));
    endfunction

    // One rising clock edge of the specified behaviour.
    task automatic model_step(input bit w, input logic [15:0] a, input logic [1:0] s, input logic [31:0] d);
        int r, sh, nbytes;
        longint unsigned old, mask, nw;
        bit tw, next_treq;
        tw = 0;
        next_treq = (m_time >= m_cmp);
        r = model_reg(a);
        if (w && r != 0 && s != 2'b11 && !(s == 2'b01 && a[0])) begin
            old    = model_word(r);
            sh     = (s == 2'b10) ? 0 : int'(a[1:0]) * 8;
            nbytes = 1 << s;
            mask   = ((64'd1 << (nbytes * 8)) - 1) << sh;
            nw     = ((old & ~mask) | ((longint'(d) << sh) & mask)) & 64'hFFFF_FFFF;
            case (r)
                1: m_msip = (nw & 1) != 0;
                2: m_cmp  = (m_cmp & 64'hFFFF_FFFF_0000_0000) | nw;
                3: m_cmp  = (m_cmp & 64'hFFFF_FFFF) | (nw << 32);
                4: begin m_time = (m_time & 64'hFFFF_FFFF_0000_0000) | nw; tw = 1; end
                5: begin m_time = (m_time & 64'hFFFF_FFFF) | (nw << 32); tw = 1; end
                default: ;
            endcase
        end
        m_cyc++;
        if (!tw && (m_cyc % DIV == 0)) m_time++;
        m_treq = next_treq;
    endtask

    task automatic cycle(input bit r, input logic [15:0] ra, input logic [1:0] rs,
                         input bit w, input logic [15:0] wa, input logic [1:0] ws, input logic [31:0] wd);
        @(negedge clk);
        check("sw_irq", sreq, m_msip);
        check("timer_irq", treq, m_treq);
        rd = r; raddr = ra; rsize = rs;
        wr = w; waddr = wa; wsize = ws; wdata = wd;
        #1;
        got = rdata;
        check("rdata", rdata, model_read(r, ra, rs));
        model_step(w, wa, ws, wd);
    endtask

    task automatic idle();
        cycle(0, 16'h0, 2'b10, 0, 16'h0, 2'b10, 32'h0);
    endtask

    task automatic rdc(input logic [15:0] a);
        cycle(1, a, 2'b10, 0, 16'h0, 2'b10, 32'h0);
    endtask

    task automatic wrc(input logic [15:0] a, input logic [1:0] s, input logic [31:0] d);
        cycle(0, 16'h0, 2'b10, 1, a, s, d);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        rd = 0; wr = 0;
        m_msip = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_time = 0; m_treq = 0; m_cyc = 0;
        model_step(0, 16'h0, 2'b10, 32'h0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; rd = 0; wr = 0;
        @(negedge clk);
        @(negedge clk);
        rd = 1; rsize = 2'b10;
        raddr = 16'h4000; #1 check("rst_cmp_lo", rdata, 32'hFFFF_FFFF);
        raddr = 16'h4004; #1 check("rst_cmp_hi", rdata, 32'hFFFF_FFFF);
        raddr = 16'h0000; #1 check("rst_msip", rdata, 32'h0);
        check("rst_treq", treq, 1'b0);
        check("rst_sreq", sreq, 1'b0);
        release_reset();
    endtask

    initial begin
        rst = 1'b0; rd = 0; wr = 0;
        raddr = '0; waddr = '0; rsize = 2'b10; wsize = 2'b10; wdata = '0;

        apply_reset();
        while (m_cyc < 100) idle();
        rdc(16'hBFF8);
        check("mtime_after_100", got, 32'(100 / DIV));

        // software interrupt
        wrc(16'h0000, 2'b10, 32'h1); idle(); check("msip_set", sreq, 1'b1);
        wrc(16'h0000, 2'b10, 32'h0); idle(); check("msip_clr", sreq, 1'b0);
        wrc(16'h0000, 2'b10, 32'hFFFF_FFFE); idle(); check("msip_bit0_only", sreq, 1'b0);

        // timer interrupt from a fresh reset
        apply_reset();
        wrc(16'h4004, 2'b10, 32'h0);
        wrc(16'h4000, 2'b10, 32'd20);
        for (int i = 0; i < 400; i++) begin
            rdc(16'hBFF8);
            if (got >= 20) break;
        end
        check("mtime_reached_20", got, 32'd20);
        check("timer_not_yet", treq, 1'b0);
        idle(); check("timer_rise", treq, 1'b1);
        wrc(16'h4000, 2'b10, 32'hFFFF_FFFF);
        idle(); check("timer_hold", treq, 1'b1);
        idle(); check("timer_clear", treq, 1'b0);

        // carry and full wrap
        wrc(16'hBFFC, 2'b10, 32'h0);
        wrc(16'hBFF8, 2'b10, 32'hFFFF_FFFF);
        for (int i = 0; i < 30 && (m_time >> 32) == 0; i++) idle();
        rdc(16'hBFFC); check("carry_hi", got, 32'h1);
        rdc(16'hBFF8);
        wrc(16'hBFFC, 2'b10, 32'hFFFF_FFFF);
        wrc(16'hBFF8, 2'b10, 32'hFFFF_FFFF);
        for (int i = 0; i < 30 && m_time > 64'hFF; i++) idle();
        rdc(16'hBFFC); check("wrap_hi", got, 32'h0);

        // write landing on an increment edge
        for (int i = 0; i < 20 && ((m_cyc + 1) % DIV) != 0; i++) idle();
        wrc(16'hBFF8, 2'b10, 32'h1234_5678);
        rdc(16'hBFF8); check("tick_write_held", got, 32'h1234_5678);
        for (int i = 0; i < 25; i++) rdc(16'hBFF8);

        // sub-word and same-cycle access
        wrc(16'h4000, 2'b10, 32'h1122_3344);
        cycle(1, 16'h4000, 2'b10, 1, 16'h4001, 2'b00, 32'h0000_00AB);
        check("same_cycle_read", got, 32'h1122_3344);
        rdc(16'h4000); check("byte_merge", got, 32'h1122_AB44);
        wrc(16'h4001, 2'b01, 32'h0000_BEEF);
        rdc(16'h4000); check("misaligned_half_ignored", got, 32'h1122_AB44);
        cycle(1, 16'h4000, 2'b11, 0, 16'h0, 2'b10, 32'h0);
        check("reserved_size_read", got, 32'h0);

        // reset asserted with a write in flight
        @(negedge clk);
        wr = 1; waddr = 16'h4000; wsize = 2'b10; wdata = 32'h0;
        rd = 1; raddr = 16'h4000; rsize = 2'b10;
        #2 rst = 1'b0;
        #1 check("async_rst_read", rdata, 32'hFFFF_FFFF);
        check("async_rst_treq", treq, 1'b0);
        check("async_rst_sreq", sreq, 1'b0);
        wr = 0;
        release_reset();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [15:0] ra, wa;
            ra = 16'(offs[$urandom_range(4)]);
            wa = 16'(offs[$urandom_range(4)]);
            if ($urandom_range(7) == 0) ra = 16'h4008;
            if ($urandom_range(7) == 0) wa = 16'hBFF4;
            ra[1:0] = 2'($urandom_range(3));
            wa[1:0] = 2'($urandom_range(3));
            cycle($urandom_range(1) == 1, ra, 2'($urandom_range(3)),
                  $urandom_range(2) == 0, wa, 2'($urandom_range(3)), $urandom);
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/clint.md
CLINT -- requirements
Module: clint

Interface
REQ-001 SHALL have parameter MTIME_DIV, default 10, mtime prescale ratio in clk cycles; used only with CLINT_MTIME_PRESCALER_EN.
REQ-002 SHALL have port clk, input, 1, sole clock.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports bus_clint_read_addr / bus_clint_write_addr, input, ADDR_WIDTH, offsets from CLINT_ADDR; the bus has already stripped the base.
REQ-005 SHALL have ports bus_clint_read_size / bus_clint_write_size, input, SIZE_WIDTH, encoded as 00=byte, 01=half, 10=word, 11=reserved.
REQ-006 SHALL have port bus_clint_data, input, REG_DATA_WIDTH, write data, right-aligned.
REQ-007 SHALL have ports bus_clint_rd / bus_clint_wr, input, 1, read and write strobes; both may be high in the same cycle.
REQ-008 SHALL have port clint_bus_data, output, BUS_DATA_WIDTH, read data.
REQ-009 SHALL have ports clint_int_timer_req / clint_int_software_req, output, 1, MTIP and MSIP levels.

Function
REQ-010 SHALL implement the map: 0x0000 msip (bit0 only); 0x4000/0x4004 mtimecmp lo/hi; 0xBFF8/0xBFFC mtime lo/hi.
REQ-011 SHALL drive reads combinationally: clint_bus_data = aligned 32-bit word at read_addr[ADDR_WIDTH-1:2], zero-extended to BUS_DATA_WIDTH, in the same cycle as bus_clint_rd; 0 when rd is low.
REQ-012 SHALL return 0 for unmapped or reserved-size reads, with no side effects.
REQ-013 SHALL commit writes at the next posedge; byte/half data lands in lane write_addr[1:0]; other bytes hold.
REQ-014 SHALL ignore writes that are unmapped, misaligned (half at odd offset) or reserved-size.
REQ-015 SHALL make same-cycle read and write of one register return the pre-write value.
REQ-016 SHALL keep mtime 64-bit, incrementing by 1 with full carry across the lo/hi halves; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
REQ-017 SHALL give a write to either mtime half precedence over the increment in that cycle, with no increment that cycle; the prescaler continues counting.
REQ-018 SHALL register clint_int_timer_req = (mtime >= mtimecmp, unsigned 64-bit), so it updates one cycle after the operands change.
REQ-019 SHALL drive clint_int_software_req = msip bit0 directly from its register.

Reset
REQ-020 SHALL set on rst low, asynchronously: mtime=0, mtimecmp=all ones, msip=0, prescaler=0, clint_int_timer_req=0.
REQ-021 SHALL resume counting from 0 on the first posedge after reset deassertion.
REQ-022 SHALL drop any write in flight when reset asserts mid-operation; the read output follows the reset register values.

Configuration
REQ-023 SHALL, with CLINT_MTIME_PRESCALER_EN defined, increment mtime once per MTIME_DIV clk cycles; the prescaler counts 0..MTIME_DIV-1 and fires on wrap.
REQ-024 SHALL, without CLINT_MTIME_PRESCALER_EN, increment mtime every cycle, with no prescaler logic.

Structure
REQ-025 SHALL place register offsets, size encodings and MTIME_DIV default in shared package clint_pkg; ADDR_WIDTH, SIZE_WIDTH, REG_DATA_WIDTH, BUS_DATA_WIDTH and CLINT_ADDR remain in config.svh.
REQ-026 SHALL isolate prescaler, mtime counter and write-override in sub-module clint_timer; clint holds decode, msip, mtimecmp and compare.

Verification
REQ-027 SHALL cover reset: rst low 2 cycles -> read 0x4000 and 0x4004 = 0xFFFFFFFF, read 0x0000 = 0, both interrupts 0.
REQ-028 SHALL cover msip: word write 0x1 to 0x0000 -> software_req=1 next cycle; write 0 -> 0; write 0xFFFFFFFE -> stays 0.
REQ-029 SHALL cover the timer interrupt: mtimecmp hi=0, lo=20 (no prescaler) -> timer_req rises exactly one cycle after mtime reaches 20; rewriting lo=0xFFFFFFFF clears it one cycle later.
REQ-030 SHALL cover the carry boundary: write mtime lo=0xFFFFFFFF, hi=0 -> after one increment read lo=0, hi=1.
REQ-031 SHALL cover sub-word and same-cycle access: byte write 0xAB to 0x4001 over mtimecmp lo=0x11223344 -> 0x1122AB44; same-cycle read of 0x4000 returns 0x11223344.
REQ-032 SHALL cover the prescaler (CLINT_MTIME_PRESCALER_EN, MTIME_DIV=10): 100 cycles after reset -> mtime=10; an mtime write at a prescaler tick -> written value held, no increment.
